// File: rtl/chess_clock_pkg.sv
// -----------------------------------------------------------------------------
// chess_clock_pkg
// Shared types and constants for the chess clock game sequencer.
//   t_bcd          : one BCD digit
//   t_preset_idx   : index into the start-time preset table
//   t_game_state   : game sequencer states
//   C_PRESETS      : start-time presets, 2-digit BCD {tens, units}
// Optional feature macro: CHESS_CLOCK_PAUSE_EN adds the PAUSE_A/PAUSE_B states.
// -----------------------------------------------------------------------------
package chess_clock_pkg;

    typedef logic [3:0] t_bcd;

    localparam int C_NUM_PRESETS  = 4;
    localparam int C_PRESET_IDX_W = 2;

    typedef logic [C_PRESET_IDX_W-1:0] t_preset_idx;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN_A  = 3'd1,
        S_RUN_B  = 3'd2,
        S_OVER_A = 3'd3,   // A won
        S_OVER_B = 3'd4    // B won
`ifdef CHESS_CLOCK_PAUSE_EN
        ,
        S_PAUSE_A = 3'd5,
        S_PAUSE_B = 3'd6
`endif
    } t_game_state;

    // Entries are never 00, so a player never starts already exhausted.
    localparam t_bcd [1:0] C_PRESETS [C_NUM_PRESETS] = '{
        {4'd0, 4'd5},
        {4'd1, 4'd0},
        {4'd3, 4'd0},
        {4'd9, 4'd9}
    };

    // Advance a preset index, wrapping after the last of n_presets entries.
    function automatic t_preset_idx next_preset(input t_preset_idx idx, input int n_presets);
        if (idx == t_preset_idx'(n_presets - 1)) begin
            return '0;
        end
        return idx + t_preset_idx'(1);
    endfunction

endpackage

// File: rtl/chess_clock_moves.sv
// -----------------------------------------------------------------------------
// chess_clock_moves
// Two-digit BCD full-move counter, wraps 99 -> 00.
//   i_clk   : system clock
//   i_rst   : asynchronous active-low reset (count -> 00)
//   i_clr   : synchronous clear, has priority over i_inc
//   i_inc   : add one move
//   o_count : BCD count, [1]=tens, [0]=units
// -----------------------------------------------------------------------------
module chess_clock_moves
    import chess_clock_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_inc,
    output t_bcd [1:0] o_count
);

    t_bcd [1:0] count_q;
    t_bcd [1:0] count_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_inc) begin
            if (count_q[0] == 4'd9) begin
                count_d[0] = 4'd0;
                count_d[1] = (count_q[1] == 4'd9) ? 4'd0 : count_q[1] + 4'd1;
            end else begin
                count_d[0] = count_q[0] + 4'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order between processes.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/chess_clock_game_ctrl.sv
// -----------------------------------------------------------------------------
// chess_clock_game_ctrl
// Game sequencer for a two-player chess clock: owns the game state, drives the
// restart/stop/win controls of both player blocks, supplies the preset start
// time and counts full moves. All outputs are registered (1-cycle latency).
//   i_clk      : system clock
//   i_rst      : asynchronous active-low reset
//   i_start    : click, start game / acknowledge game over (pause/resume with
//                CHESS_CLOCK_PAUSE_EN)
//   i_preset   : click, advance preset index (IDLE only)
//   i_turn_a/b : click, player ends its move
//   i_zero_a/b : level, player's time exhausted
//   o_restart  : hold player counters at init
//   o_init     : BCD start time, [1]=tens, [0]=units
//   o_stop_a/b : freeze player countdown
//   o_win_a/b  : winner flags
//   o_active   : one-hot running player {b,a}
//   o_moves    : BCD full-move count
// Optional feature macro: CHESS_CLOCK_PAUSE_EN (i_start pauses/resumes a game).
// -----------------------------------------------------------------------------
module chess_clock_game_ctrl
    import chess_clock_pkg::*;
#(
    parameter int p_presets    = C_NUM_PRESETS,
    parameter int p_preset_def = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_preset,
    input  logic       i_turn_a,
    input  logic       i_turn_b,
    input  logic       i_zero_a,
    input  logic       i_zero_b,
    output logic       o_restart,
    output t_bcd [1:0] o_init,
    output logic       o_stop_a,
    output logic       o_stop_b,
    output logic       o_win_a,
    output logic       o_win_b,
    output logic [1:0] o_active,
    output t_bcd [1:0] o_moves
);

    t_game_state state_q, state_d;
    t_preset_idx preset_idx_q, preset_idx_d;
    t_bcd [1:0]  init_q, init_d;
    logic        restart_q, restart_d;
    logic        stop_a_q, stop_a_d;
    logic        stop_b_q, stop_b_d;
    logic        win_a_q, win_a_d;
    logic        win_b_q, win_b_d;
    logic [1:0]  active_q, active_d;
    logic        moves_clr;
    logic        moves_inc;

    // Next-state logic. Time-out beats a same-cycle turn click, and a turn
    // click beats a same-cycle pause request.
    always_comb begin
        state_d      = state_q;
        preset_idx_d = preset_idx_q;
        moves_inc    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_RUN_A;
                end else if (i_preset) begin
                    preset_idx_d = next_preset(preset_idx_q, p_presets);
                end
            end
            S_RUN_A: begin
                if (i_zero_a) begin
                    state_d = S_OVER_B;
                end else if (i_turn_a) begin
                    state_d = S_RUN_B;
`ifdef CHESS_CLOCK_PAUSE_EN
                end else if (i_start) begin
                    state_d = S_PAUSE_A;
`endif
                end
            end
            S_RUN_B: begin
                if (i_zero_b) begin
                    state_d = S_OVER_A;
                end else if (i_turn_b) begin
                    state_d   = S_RUN_A;
                    moves_inc = 1'b1;   // B's move closes a full move
`ifdef CHESS_CLOCK_PAUSE_EN
                end else if (i_start) begin
                    state_d = S_PAUSE_B;
`endif
                end
            end
`ifdef CHESS_CLOCK_PAUSE_EN
            S_PAUSE_A: if (i_start) state_d = S_RUN_A;
            S_PAUSE_B: if (i_start) state_d = S_RUN_B;
`endif
            S_OVER_A, S_OVER_B: begin
                if (i_start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so they change on
    // the same edge as the state itself.
    always_comb begin
        init_d    = C_PRESETS[preset_idx_d];
        restart_d = (state_d == S_IDLE);
        stop_a_d  = (state_d != S_RUN_A);
        stop_b_d  = (state_d != S_RUN_B);
        win_a_d   = (state_d == S_OVER_A);
        win_b_d   = (state_d == S_OVER_B);
        active_d  = {(state_d == S_RUN_B), (state_d == S_RUN_A)};
        // Counter is cleared on entry to (and while in) IDLE; OVER keeps it frozen.
        moves_clr = (state_d == S_IDLE);
    end

    // NOTE: only control flops live here; the preset table is a constant, so
    // there is no memory array that would need (or resist) a reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= S_IDLE;
            preset_idx_q <= t_preset_idx'(p_preset_def);
            init_q       <= C_PRESETS[p_preset_def];
            restart_q    <= 1'b1;
            stop_a_q     <= 1'b1;
            stop_b_q     <= 1'b1;
            win_a_q      <= 1'b0;
            win_b_q      <= 1'b0;
            active_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            preset_idx_q <= preset_idx_d;
            init_q       <= init_d;
            restart_q    <= restart_d;
            stop_a_q     <= stop_a_d;
            stop_b_q     <= stop_b_d;
            win_a_q      <= win_a_d;
            win_b_q      <= win_b_d;
            active_q     <= active_d;
        end
    end

    chess_clock_moves u_moves (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (moves_clr),
        .i_inc   (moves_inc),
        .o_count (o_moves)
    );

    assign o_restart = restart_q;
    assign o_init    = init_q;
    assign o_stop_a  = stop_a_q;
    assign o_stop_b  = stop_b_q;
    assign o_win_a   = win_a_q;
    assign o_win_b   = win_b_q;
    assign o_active  = active_q;

endmodule

// File: tb/tb_chess_clock_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_chess_clock_game_ctrl
// Self-checking bench: a behavioural game model predicts the full output
// vector for every driven cycle; predictions are queued at drive time and
// compared one cycle later, just after the active clock edge.
// Output vector: {restart, init[7:0], stop_a, stop_b, win_a, win_b,
//                 active[1:0], moves[7:0]}
// -----------------------------------------------------------------------------
module tb_chess_clock_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, preset, turn_a, turn_b, zero_a, zero_b;
    logic       o_restart, o_stop_a, o_stop_b, o_win_a, o_win_b;
    logic [1:0] o_active;
    logic [1:0][3:0] o_init;
    logic [1:0][3:0] o_moves;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [22:0] exp;
    } t_exp;
    t_exp exp_q[$];

    // Model state
    localparam int M_IDLE = 0, M_RA = 1, M_RB = 2, M_OA = 3, M_OB = 4, M_PA = 5, M_PB = 6;
    logic [7:0] tbl [4] = '{8'h05, 8'h10, 8'h30, 8'h99};
    int m_st, m_idx, m_moves;

    chess_clock_game_ctrl #(.p_presets(4), .p_preset_def(1)) dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_start   (start),
        .i_preset  (preset),
        .i_turn_a  (turn_a),
        .i_turn_b  (turn_b),
        .i_zero_a  (zero_a),
        .i_zero_b  (zero_b),
        .o_restart (o_restart),
        .o_init    (o_init),
        .o_stop_a  (o_stop_a),
        .o_stop_b  (o_stop_b),
        .o_win_a   (o_win_a),
        .o_win_b   (o_win_b),
        .o_active  (o_active),
        .o_moves   (o_moves)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [22:0] got, input logic [22:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    function automatic logic [22:0] dut_vec();
        return {o_restart, o_init, o_stop_a, o_stop_b, o_win_a, o_win_b, o_active, o_moves};
    endfunction

    function automatic logic [22:0] model_vec();
        logic [7:0] mv;
        mv[7:4] = 4'(m_moves / 10);
        mv[3:0] = 4'(m_moves % 10);
        return {(m_st == M_IDLE), tbl[m_idx], (m_st != M_RA), (m_st != M_RB),
                (m_st == M_OA), (m_st == M_OB), (m_st == M_RB), (m_st == M_RA), mv};
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_idx = 1; m_moves = 0;
    endtask

    task automatic model_step(input bit st, input bit pr, input bit ta, input bit tb_, input bit za, input bit zb);
        case (m_st)
            M_IDLE: if (st) m_st = M_RA; else if (pr) m_idx = (m_idx + 1) % 4;
            M_RA: begin
                if (za) m_st = M_OB;
                else if (ta) m_st = M_RB;
`ifdef CHESS_CLOCK_PAUSE_EN
                else if (st) m_st = M_PA;
`endif
            end
            M_RB: begin
                if (zb) m_st = M_OA;
                else if (tb_) begin m_st = M_RA; m_moves = (m_moves + 1) % 100; end
`ifdef CHESS_CLOCK_PAUSE_EN
                else if (st) m_st = M_PB;
`endif
            end
            M_PA: if (st) m_st = M_RA;
            M_PB: if (st) m_st = M_RB;
            default: if (st) begin m_st = M_IDLE; m_moves = 0; end
        endcase
    endtask

    // Drive one cycle of inputs and queue the prediction for the next edge.
    task automatic step(input string tag, input bit st = 0, input bit pr = 0,
                        input bit ta = 0, input bit tb_ = 0, input bit za = 0, input bit zb = 0);
        t_exp e;
        @(negedge clk);
        start = st; preset = pr; turn_a = ta; turn_b = tb_; zero_a = za; zero_b = zb;
        model_step(st, pr, ta, tb_, za, zb);
        e.tag = tag;
        e.exp = model_vec();
        exp_q.push_back(e);
    endtask

    // Monitor: compare just after each rising edge.
    initial begin
        t_exp e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.tag, dut_vec(), e.exp);
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start = 0; preset = 0; turn_a = 0; turn_b = 0; zero_a = 0; zero_b = 0;
        model_reset();
        #12;
        check("reset_values", dut_vec(), model_vec());
        @(negedge clk);
        rst_n = 1'b1;

        step("idle");
        step("idle_zero_ignored", 0, 0, 0, 0, 1, 1);
        // Preset cycling: 10 -> 30 -> 99 -> 05 -> 10
        for (int i = 0; i < 4; i++) begin
            step("preset_click", 0, 1);
            step("preset_hold");
        end
        step("preset_click", 0, 1);   // -> 30
        step("start_and_preset", 1, 1);   // start wins, preset unchanged
        step("run_a_turn_b_ignored", 0, 0, 0, 1);
        step("run_a_zero_b_ignored", 0, 0, 0, 0, 0, 1);
        step("run_a_preset_ignored", 0, 1);
`ifdef CHESS_CLOCK_PAUSE_EN
        step("pause_a", 1);
        step("pause_turn_ignored", 0, 0, 1);
        step("pause_zero_ignored", 0, 0, 0, 0, 1);
        step("resume_a", 1);
`else
        step("run_a_start_ignored", 1);
        step("run_a_start_ignored2", 1);
`endif
        step("turn_a", 0, 0, 1);
        step("turn_b_first_move", 0, 0, 0, 1);
        // 100 full moves: passes 09->10 and 99->00
        for (int i = 0; i < 100; i++) begin
            step("move_turn_a", 0, 0, 1);
            step("move_turn_b", 0, 0, 0, 1);
        end
        step("zero_and_turn_a", 0, 0, 1, 0, 1);   // B wins, no move
        step("over_b_hold", 0, 0, 1, 1);
        step("over_b_ack", 1);
        step("idle_again");
        step("start2", 1);
        step("turn_a2", 0, 0, 1);
        step("zero_and_turn_b", 0, 0, 0, 1, 0, 1);   // A wins, no move
        step("over_a_hold");
        step("over_a_ack", 1);
        step("start3", 1);
        step("turn_a3", 0, 0, 1);
        step("run_b_hold");

        // Async reset mid RUN_B, checked before the next edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_mid_game", dut_vec(), model_vec());
        @(negedge clk);
        rst_n = 1'b1;
        step("after_reset_idle");
        step("after_reset_preset", 0, 1);
        step("flush");
        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d pending, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
